wavemem_wr_pipe: RTL and testbench
==================================

Name: wavemem_wr_pipe

Overview:
Parametrised write-path pipeline for the waveform sample RAM. It carries write-enable, address and data through a configurable number of register stages, keeping all three aligned. It adds burst mode, where an internal looping address generator replaces the per-sample address so the host can stream samples. It also supports pipeline hold, flush and a write-retire counter, and sits between the host/loader interface and the waveform RAM write port.

Parameters:
AW, 12, address width (bits)
DW, 12, sample data width (bits)
STAGES, 2, pipeline depth, legal range 1..8
CW, 16, width of retired-write counter

Ports:
Clock  input  1  single rising-edge clock
Reset  input  1  synchronous, active-high reset
Win  input  1  write request for the current cycle
Ain  input  AW  direct write address (Burst=0); burst base address on Load
Din  input  DW  write data sample
Burst  input  1  1 = address from internal generator, 0 = address from Ain
Load  input  1  load burst generator: Base<=Ain, Ptr<=Ain
Limit  input  AW  last burst address; the address after Limit wraps to Base
Hold  input  1  freeze every pipeline stage and the generator
Flush  input  1  discard all in-flight writes
Wout  output  1  write enable to the RAM
Aout  output  AW  write address to the RAM
Dout  output  DW  write data to the RAM
Busy  output  1  1 while any stage holds a valid write
WrCount  output  CW  count of writes issued on Wout, wraps modulo 2^CW

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge): all stage valid bits=0; all stage address/data=0; Base=0; Ptr=0; WrCount=0. Outputs read Wout=0, Aout=0, Dout=0, Busy=0, WrCount=0 on the next cycle. Reset overrides every other input.
- Stage 0 capture each unheld cycle:
  - valid0=Win.
  - addr0=Ain when Burst=0. When Burst=1, addr0=Ain if Load=1 that cycle, else Ptr.
  - data0=Din.
- Stages 1..STAGES-1 shift one per unheld cycle. The output stage is stage STAGES-1.
- Latency: exactly STAGES cycles from a Win sample to Wout=1. Wout, Aout and Dout are always aligned to the same stage, with no skew between enable and address/data.
- Address/data of a stage update only when its incoming valid=1. Otherwise they keep the previous value, so Aout/Dout hold the last written values while Wout=0.
- Burst generator:
  - Load=1 sets Base<=Ain. Ptr is loaded as follows: Ptr<=Ain when Win=0 or Burst=0; Ptr<=next(Ain) when Win=1 and Burst=1.
  - Win=1 & Burst=1 & Load=0: Ptr<=next(Ptr).
  - next(x) = Base when x==Limit (using the Base value after any same-cycle Load), else x+1 modulo 2^AW.
  - When Limit is below Base, the generator wraps through 2^AW-1 to 0 and continues to Limit.
  - Burst=0 writes do not move Ptr.
- Hold=1: no stage, Ptr, Base or WrCount changes; outputs are held (Wout stays at its held value). Inputs presented during Hold are dropped. The upstream source must not assert Win while Hold=1.
- Flush=1: all valid bits cleared at the edge, so Wout=0 from the next cycle until new writes emerge. Stage address/data are kept. Base and Ptr are kept. Win in the Flush cycle is discarded.
- Flush and Hold together: Flush wins and clears valid bits. Load in a Flush cycle is still applied.
- WrCount increments by 1 in every cycle where Wout=1 and Hold=0, and wraps from 2^CW-1 to 0.
- Busy = OR of all stage valid bits, including the output stage.
- STAGES=1 is a single register; all rules above still apply.

Test Plan:
- Direct pipeline, STAGES=2: Win=1, Ain=0x123, Din=0xABC at cycle 0, then idle. Require Wout=1, Aout=0x123, Dout=0xABC at cycle 2 only. Require Busy=1 in cycles 1-2 and WrCount=1 afterwards.
- Burst wrap: Load with Ain=0x010, Limit=0x012, then Burst=1 & Win=1 for 5 cycles with Din=1..5. Require output addresses 0x010, 0x011, 0x012, 0x010, 0x011 with data 1..5 in order.
- Hold: stream 4 writes and assert Hold for 3 cycles mid-stream. Require outputs frozen for 3 cycles, no write lost or duplicated, and WrCount=4 at the end.
- Flush: two writes in flight, Flush=1. Require Wout=0 for the following 2 cycles, WrCount unchanged and Busy=0 one cycle after Flush.
- Reset mid-burst: Reset=1 while Busy=1 and Ptr=0x7FF. Require all outputs 0 next cycle. A subsequent Burst write with no Load must use address 0x000.
- Parameter sweep: STAGES=1, 8 and AW=DW=16. Require latency equal to STAGES and wrap from 0xFFFF to Base when Limit=0xFFFF.

Source files
------------

// File: rtl/wavemem_wr_pipe.sv
// wavemem_wr_pipe: write-path pipeline for the waveform sample RAM.
// Carries write enable, address and data through STAGES aligned register
// stages. A looping burst address generator can replace the per-sample
// address, and the pipeline supports hold, flush and a retired-write counter.
//
// Ports:
//   Clock    rising-edge clock
//   Reset    synchronous active-high reset, overrides every other input
//   Win      write request this cycle
//   Ain      direct write address (Burst=0) / burst base address on Load
//   Din      write data sample
//   Burst    1 = address taken from the burst generator
//   Load     load burst generator: Base<=Ain, Ptr<=Ain (or next(Ain))
//   Limit    last burst address; the address after Limit wraps to Base
//   Hold     freeze all stages, generator and counter
//   Flush    drop all in-flight writes
//   Wout     RAM write enable (output stage valid)
//   Aout     RAM write address (output stage)
//   Dout     RAM write data (output stage)
//   Busy     any stage holds a valid write
//   WrCount  writes issued on Wout, modulo 2^CW
module wavemem_wr_pipe #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 12,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CW     = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Win,
    input  logic [AW-1:0] Ain,
    input  logic [DW-1:0] Din,
    input  logic          Burst,
    input  logic          Load,
    input  logic [AW-1:0] Limit,
    input  logic          Hold,
    input  logic          Flush,
    output logic          Wout,
    output logic [AW-1:0] Aout,
    output logic [DW-1:0] Dout,
    output logic          Busy,
    output logic [CW-1:0] WrCount
);

    localparam int unsigned SL = STAGES - 1;

    // Pipeline state
    logic [STAGES-1:0] valid_q, valid_n;
    logic [AW-1:0]     addr_q [STAGES];
    logic [AW-1:0]     addr_n [STAGES];
    logic [DW-1:0]     data_q [STAGES];
    logic [DW-1:0]     data_n [STAGES];

    // Burst generator, counter and busy flag
    logic [AW-1:0] base_q, base_n;
    logic [AW-1:0] ptr_q, ptr_n;
    logic [AW-1:0] base_eff;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          busy_q;

    // Next burst address: wrap to the (possibly just loaded) base after Limit
    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0] x,
        input logic [AW-1:0] lim,
        input logic [AW-1:0] base
    );
        if (x == lim) begin
            return base;
        end
        return x + AW'(1);
    endfunction

    // Next-state logic for stages, generator and counter
    always_comb begin
        valid_n  = valid_q;
        addr_n   = addr_q;
        data_n   = data_q;
        base_n   = base_q;
        ptr_n    = ptr_q;
        cnt_n    = cnt_q;
        base_eff = Load ? Ain : base_q;

        if (Flush) begin
            // Flush beats Hold; Win is discarded but Load still takes effect
            valid_n = '0;
            if (Load) begin
                base_n = Ain;
                ptr_n  = Ain;
            end
        end else if (!Hold) begin
            valid_n[0] = Win;
            if (Win) begin
                addr_n[0] = (Burst && !Load) ? ptr_q : Ain;
                data_n[0] = Din;
            end

            // Address/data only move with a valid write so outputs keep the last write
            for (int i = 1; i < int'(STAGES); i++) begin
                valid_n[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    addr_n[i] = addr_q[i-1];
                    data_n[i] = data_q[i-1];
                end
            end

            if (Load) begin
                base_n = Ain;
                ptr_n  = (Win && Burst) ? next_addr(Ain, Limit, base_eff) : Ain;
            end else if (Win && Burst) begin
                ptr_n = next_addr(ptr_q, Limit, base_eff);
            end
        end

        // A write retires in each unheld cycle it is presented on Wout
        if (valid_q[SL] && !Hold) begin
            cnt_n = cnt_q + CW'(1);
        end
    end

    // State registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            base_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            valid_q <= valid_n;
            for (int i = 0; i < int'(STAGES); i++) begin
                addr_q[i] <= addr_n[i];
                data_q[i] <= data_n[i];
            end
            base_q <= base_n;
            ptr_q  <= ptr_n;
            cnt_q  <= cnt_n;
            busy_q <= |valid_n;
        end
    end

    assign Wout    = valid_q[SL];
    assign Aout    = addr_q[SL];
    assign Dout    = data_q[SL];
    assign Busy    = busy_q;
    assign WrCount = cnt_q;

endmodule

// File: tb/tb_wavemem_wr_pipe.sv
module tb_wavemem_wr_pipe;

    logic        Clock = 1'b0;
    logic        Reset, Win, Burst, Load, Hold, Flush;
    logic [11:0] Ain, Din, Limit;
    logic        Wout, Busy;
    logic [11:0] Aout, Dout;
    logic [15:0] WrCount;

    logic        h_rst, h_win, h_burst, h_load, h_hold, h_flush;
    logic [15:0] h_ain, h_din, h_limit;
    logic        o1_wout, o1_busy, o8_wout, o8_busy;
    logic [15:0] o1_aout, o1_dout, o1_wrcount, o8_aout, o8_dout, o8_wrcount;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] bexp [5] = '{12'h010, 12'h011, 12'h012, 12'h010, 12'h011};
    logic [15:0] wexp [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFE};

    always #5 Clock = ~Clock;

    wavemem_wr_pipe #(.AW(12), .DW(12), .STAGES(2), .CW(16)) u_dut (
        .Clock(Clock), .Reset(Reset), .Win(Win), .Ain(Ain), .Din(Din),
        .Burst(Burst), .Load(Load), .Limit(Limit), .Hold(Hold), .Flush(Flush),
        .Wout(Wout), .Aout(Aout), .Dout(Dout), .Busy(Busy), .WrCount(WrCount)
    );

    wavemem_wr_pipe #(.AW(16), .DW(16), .STAGES(1), .CW(16)) u_s1 (
        .Clock(Clock), .Reset(h_rst), .Win(h_win), .Ain(h_ain), .Din(h_din),
        .Burst(h_burst), .Load(h_load), .Limit(h_limit), .Hold(h_hold), .Flush(h_flush),
        .Wout(o1_wout), .Aout(o1_aout), .Dout(o1_dout), .Busy(o1_busy), .WrCount(o1_wrcount)
    );

    wavemem_wr_pipe #(.AW(16), .DW(16), .STAGES(8), .CW(16)) u_s8 (
        .Clock(Clock), .Reset(h_rst), .Win(h_win), .Ain(h_ain), .Din(h_din),
        .Burst(h_burst), .Load(h_load), .Limit(h_limit), .Hold(h_hold), .Flush(h_flush),
        .Wout(o8_wout), .Aout(o8_aout), .Dout(o8_dout), .Busy(o8_busy), .WrCount(o8_wrcount)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; Win = 1'b0; Ain = '0; Din = '0; Burst = 1'b0;
        Load = 1'b0; Limit = '0; Hold = 1'b0; Flush = 1'b0;
        h_rst = 1'b1; h_win = 1'b0; h_ain = '0; h_din = '0; h_burst = 1'b0;
        h_load = 1'b0; h_limit = '0; h_hold = 1'b0; h_flush = 1'b0;
        tick(); tick();
        Reset = 1'b0; h_rst = 1'b0;

        // Reset state
        chk("rst_wout", 32'(Wout), 0);
        chk("rst_aout", 32'(Aout), 0);
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_cnt", 32'(WrCount), 0);

        // Single direct write, latency 2
        Win = 1'b1; Ain = 12'h123; Din = 12'hABC; tick();
        Win = 1'b0; Ain = '0; Din = '0;
        chk("dir_c1_wout", 32'(Wout), 0);
        chk("dir_c1_busy", 32'(Busy), 1);
        tick();
        chk("dir_c2_wout", 32'(Wout), 1);
        chk("dir_c2_aout", 32'(Aout), 32'h123);
        chk("dir_c2_dout", 32'(Dout), 32'hABC);
        chk("dir_c2_busy", 32'(Busy), 1);
        chk("dir_c2_cnt", 32'(WrCount), 0);
        tick();
        chk("dir_c3_wout", 32'(Wout), 0);
        chk("dir_c3_busy", 32'(Busy), 0);
        chk("dir_c3_cnt", 32'(WrCount), 1);
        chk("dir_c3_aout_kept", 32'(Aout), 32'h123);

        // Burst wrap 0x010..0x012
        Load = 1'b1; Ain = 12'h010; Limit = 12'h012; tick();
        Load = 1'b0; Ain = '0; Burst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            Win = (c < 5);
            Din = 12'(c + 1);
            tick();
            if (c >= 1) begin
                chk("bw_wout", 32'(Wout), 1);
                chk("bw_aout", 32'(Aout), 32'(bexp[c-1]));
                chk("bw_dout", 32'(Dout), 32'(c));
            end
        end
        Win = 1'b0; Burst = 1'b0; tick();
        chk("bw_cnt", 32'(WrCount), 6);
        chk("bw_end_wout", 32'(Wout), 0);
        chk("bw_end_busy", 32'(Busy), 0);

        // Load together with a burst write: first at Ain, then next(Ain), then wrap
        Load = 1'b1; Win = 1'b1; Burst = 1'b1; Ain = 12'h020; Limit = 12'h021; Din = 12'h007;
        tick();
        Load = 1'b0; Ain = '0; Din = 12'h008; tick();
        chk("lb0_aout", 32'(Aout), 32'h020);
        chk("lb0_dout", 32'(Dout), 32'h007);
        Din = 12'h009; tick();
        chk("lb1_aout", 32'(Aout), 32'h021);
        chk("lb1_dout", 32'(Dout), 32'h008);
        Win = 1'b0; Burst = 1'b0; tick();
        chk("lb2_aout", 32'(Aout), 32'h020);
        chk("lb2_dout", 32'(Dout), 32'h009);
        tick();
        chk("lb_cnt", 32'(WrCount), 9);

        // Hold for 3 cycles mid-stream
        Win = 1'b1; Ain = 12'h100; Din = 12'h200; tick();
        Ain = 12'h101; Din = 12'h201; tick();
        Win = 1'b0; Hold = 1'b1;
        chk("hold_c2_aout", 32'(Aout), 32'h100);
        tick();
        chk("hold_c3_wout", 32'(Wout), 1);
        chk("hold_c3_aout", 32'(Aout), 32'h100);
        chk("hold_c3_cnt", 32'(WrCount), 9);
        tick();
        chk("hold_c4_dout", 32'(Dout), 32'h200);
        tick();
        chk("hold_c5_aout", 32'(Aout), 32'h100);
        chk("hold_c5_cnt", 32'(WrCount), 9);
        Hold = 1'b0; Win = 1'b1; Ain = 12'h102; Din = 12'h202; tick();
        chk("hold_c6_aout", 32'(Aout), 32'h101);
        chk("hold_c6_dout", 32'(Dout), 32'h201);
        chk("hold_c6_cnt", 32'(WrCount), 10);
        Ain = 12'h103; Din = 12'h203; tick();
        chk("hold_c7_aout", 32'(Aout), 32'h102);
        Win = 1'b0; tick();
        chk("hold_c8_aout", 32'(Aout), 32'h103);
        chk("hold_c8_wout", 32'(Wout), 1);
        tick();
        chk("hold_c9_wout", 32'(Wout), 0);
        chk("hold_cnt", 32'(WrCount), 13);

        // Flush with two writes in flight; Load in the flush cycle still applies
        Win = 1'b1; Ain = 12'h300; Din = 12'h003; tick();
        Ain = 12'h301; Din = 12'h004; tick();
        chk("fl_pre_busy", 32'(Busy), 1);
        Flush = 1'b1; Load = 1'b1; Burst = 1'b1; Win = 1'b1; Ain = 12'h7FE; Limit = 12'h7FF;
        Din = 12'h005; tick();
        Flush = 1'b0; Load = 1'b0; Burst = 1'b0; Win = 1'b0; Ain = '0;
        chk("fl_c1_wout", 32'(Wout), 0);
        chk("fl_c1_busy", 32'(Busy), 0);
        chk("fl_c1_cnt", 32'(WrCount), 14);
        chk("fl_c1_aout_kept", 32'(Aout), 32'h300);
        tick();
        chk("fl_c2_wout", 32'(Wout), 0);
        chk("fl_c2_cnt", 32'(WrCount), 14);

        // Burst write from the pointer loaded during the flush
        Win = 1'b1; Burst = 1'b1; Ain = 12'h555; Din = 12'h006; tick();
        Win = 1'b0; Burst = 1'b0; tick();
        chk("flb_wout", 32'(Wout), 1);
        chk("flb_aout", 32'(Aout), 32'h7FE);
        chk("flb_busy", 32'(Busy), 1);

        // Reset while busy with Ptr at 0x7FF
        Reset = 1'b1; tick();
        Reset = 1'b0;
        chk("mr_wout", 32'(Wout), 0);
        chk("mr_aout", 32'(Aout), 0);
        chk("mr_dout", 32'(Dout), 0);
        chk("mr_busy", 32'(Busy), 0);
        chk("mr_cnt", 32'(WrCount), 0);
        Win = 1'b1; Burst = 1'b1; Ain = 12'h555; Din = 12'h5A5; tick();
        Win = 1'b0; Burst = 1'b0; tick();
        chk("mr_bw_wout", 32'(Wout), 1);
        chk("mr_bw_aout", 32'(Aout), 0);
        chk("mr_bw_dout", 32'(Dout), 32'h5A5);

        // STAGES=1 / STAGES=8 latency, 16-bit paths
        h_win = 1'b1; h_ain = 16'hABCD; h_din = 16'h1234; tick();
        h_win = 1'b0;
        chk("s1_wout", 32'(o1_wout), 1);
        chk("s1_aout", 32'(o1_aout), 32'hABCD);
        chk("s1_dout", 32'(o1_dout), 32'h1234);
        chk("s8_lat_1", 32'(o8_wout), 0);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk("s8_lat", 32'(o8_wout), 32'(k == 8));
        end
        chk("s8_aout", 32'(o8_aout), 32'hABCD);

        // Wrap at the top of the 16-bit address space
        h_load = 1'b1; h_ain = 16'hFFFE; h_limit = 16'hFFFF; tick();
        h_load = 1'b0; h_ain = '0; h_burst = 1'b1; h_win = 1'b1;
        for (int k = 0; k < 3; k++) begin
            h_din = 16'(k + 1);
            tick();
            chk("s1_wrap_aout", 32'(o1_aout), 32'(wexp[k]));
            chk("s1_wrap_dout", 32'(o1_dout), 32'(k + 1));
        end
        h_win = 1'b0; h_burst = 1'b0;
        repeat (7) tick();
        chk("s8_wrap_wout", 32'(o8_wout), 1);
        chk("s8_wrap_aout", 32'(o8_aout), 32'hFFFE);
        chk("s8_wrap_dout", 32'(o8_dout), 3);
        chk("s1_cnt", 32'(o1_wrcount), 4);
        chk("s8_cnt", 32'(o8_wrcount), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
